// File: rtl/parking_pkg.sv
// Shared types for the parking lot counter: per-lane sequencer states,
// lane event encoding and a small popcount helper.
package parking_pkg;

  localparam int MAX_LANES = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EN1  = 3'd1,
    ST_EN2  = 3'd2,
    ST_EN3  = 3'd3,
    ST_EX1  = 3'd4,
    ST_EX2  = 3'd5,
    ST_EX3  = 3'd6
  } lane_state_t;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_ENTER = 2'd1,
    EV_EXIT  = 2'd2
  } lane_ev_t;

  function automatic logic [3:0] count_ones(input logic [MAX_LANES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/parking_lane_fsm.sv
// One gate lane: decodes the outer/inner beam pair into entry/exit passes and
// emits a registered one-cycle pulse when a pass completes.
//
// state | meaning
// IDLE  | both beams clear, no pass in progress
// EN1   | entering: only outer beam blocked
// EN2   | entering: both beams blocked
// EN3   | entering: only inner beam blocked
// EX1   | exiting: only inner beam blocked
// EX2   | exiting: both beams blocked
// EX3   | exiting: only outer beam blocked
module parking_lane_fsm
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter_ev,
  output logic exit_ev
);

  lane_state_t state, state_next;
  lane_ev_t    ev_next;
  logic [1:0]  ab, ba;

  assign ab = {a, b};
  assign ba = {b, a};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      enter_ev <= 1'b0;
      exit_ev  <= 1'b0;
    end else begin
      state    <= state_next;
      enter_ev <= (ev_next == EV_ENTER);
      exit_ev  <= (ev_next == EV_EXIT);
    end
  end

  // Exit states walk the same shape as entry states with the beams swapped.
  always_comb begin
    state_next = state;
    ev_next    = EV_NONE;
    case (state)
      ST_IDLE: begin
        if (ab == 2'b10)      state_next = ST_EN1;
        else if (ab == 2'b01) state_next = ST_EX1;
      end
      ST_EN1: begin
        if (ab == 2'b11)      state_next = ST_EN2;
        else if (ab != 2'b10) state_next = ST_IDLE;
      end
      ST_EN2: begin
        case (ab)
          2'b01:   state_next = ST_EN3;
          2'b10:   state_next = ST_EN1;
          2'b11:   state_next = ST_EN2;
          default: state_next = ST_IDLE;
        endcase
      end
      ST_EN3: begin
        case (ab)
          2'b00: begin
            state_next = ST_IDLE;
            ev_next    = EV_ENTER;
          end
          2'b11:   state_next = ST_EN2;
          2'b01:   state_next = ST_EN3;
          default: state_next = ST_IDLE;
        endcase
      end
      ST_EX1: begin
        if (ba == 2'b11)      state_next = ST_EX2;
        else if (ba != 2'b10) state_next = ST_IDLE;
      end
      ST_EX2: begin
        case (ba)
          2'b01:   state_next = ST_EX3;
          2'b10:   state_next = ST_EX1;
          2'b11:   state_next = ST_EX2;
          default: state_next = ST_IDLE;
        endcase
      end
      ST_EX3: begin
        case (ba)
          2'b00: begin
            state_next = ST_IDLE;
            ev_next    = EV_EXIT;
          end
          2'b11:   state_next = ST_EX2;
          2'b01:   state_next = ST_EX3;
          default: state_next = ST_IDLE;
        endcase
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/parking_lot_counter.sv
// Parking lot occupancy counter: N_LANES independent gate sequencers feed a
// saturating occupancy register with sticky overflow/underflow flags.
module parking_lot_counter
  import parking_pkg::*;
#(
  parameter int N_LANES  = 2,
  parameter int CAPACITY = 100,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_LANES-1:0] a,
  input  logic [N_LANES-1:0] b,
  input  logic               clr_err,
  output logic [N_LANES-1:0] enter_ev,
  output logic [N_LANES-1:0] exit_ev,
  output logic [CNT_W-1:0]   occupancy,
  output logic               full,
  output logic               empty,
  output logic               ovf,
  output logic               unf
);

  localparam int SW = CNT_W + 4;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    parking_lane_fsm u_lane (
      .clk      (clk),
      .reset    (reset),
      .a        (a[g]),
      .b        (b[g]),
      .enter_ev (enter_ev[g]),
      .exit_ev  (exit_ev[g])
    );
  end

  logic [MAX_LANES-1:0] enter_pad, exit_pad;
  logic [3:0]           n_enter, n_exit;
  logic signed [SW-1:0] sum;
  logic [CNT_W-1:0]     occ_next;
  logic                 clamp_hi, clamp_lo;

  always_comb begin
    enter_pad              = '0;
    exit_pad               = '0;
    enter_pad[N_LANES-1:0] = enter_ev;
    exit_pad[N_LANES-1:0]  = exit_ev;
    n_enter                = count_ones(enter_pad);
    n_exit                 = count_ones(exit_pad);
  end

  always_comb begin
    sum      = $signed({4'b0000, occupancy}) + $signed(SW'(n_enter)) - $signed(SW'(n_exit));
    occ_next = sum[CNT_W-1:0];
    clamp_hi = 1'b0;
    clamp_lo = 1'b0;
    if (sum > $signed(SW'(CAPACITY))) begin
      occ_next = CNT_W'(CAPACITY);
      clamp_hi = 1'b1;
    end else if (sum < $signed(SW'(0))) begin
      occ_next = '0;
      clamp_lo = 1'b1;
    end
  end

  // A clamp in the same cycle as clr_err keeps its flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      occupancy <= occ_next;
      ovf       <= clamp_hi | (ovf & ~clr_err);
      unf       <= clamp_lo | (unf & ~clr_err);
    end
  end

  assign full  = (occupancy == CNT_W'(CAPACITY));
  assign empty = (occupancy == '0);

endmodule

// File: doc/parking_lot_counter.md
PARKING_LOT_COUNTER -- requirements
Module: parking_lot_counter

Interface
REQ-001 Parameter N_LANES, default 2, number of independent gate lanes (1..8).
REQ-002 Parameter CAPACITY, default 100, maximum occupancy (1..2**CNT_W-1).
REQ-003 Parameter CNT_W, default 8, occupancy counter width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 a  in  N_LANES  outer photo-sensor per lane; 1 = beam blocked.
REQ-007 b  in  N_LANES  inner photo-sensor per lane; 1 = beam blocked.
REQ-008 clr_err  in  1  one-cycle pulse; clears sticky ovf/unf.
REQ-009 enter_ev  out  N_LANES  one-cycle pulse per lane on completed entry.
REQ-010 exit_ev  out  N_LANES  one-cycle pulse per lane on completed exit.
REQ-011 occupancy  out  CNT_W  current car count.
REQ-012 full  out  1  high iff occupancy == CAPACITY.
REQ-013 empty  out  1  high iff occupancy == 0.
REQ-014 ovf  out  1  sticky; an update was clamped at CAPACITY.
REQ-015 unf  out  1  sticky; an update was clamped at 0.

Function
REQ-016 Each lane SHALL run an independent 7-state FSM on its {a,b} pair: IDLE, EN1, EN2, EN3, EX1, EX2, EX3.
REQ-017 IDLE: ab=10 -> EN1; ab=01 -> EX1; ab=00 or 11 -> stay IDLE.
REQ-018 EN1: 11 -> EN2; 10 -> stay; 00 or 01 -> IDLE (abort, no event).
REQ-019 EN2: 01 -> EN3; 10 -> EN1 (car backing); 11 -> stay; 00 -> IDLE (abort).
REQ-020 EN3: 00 -> IDLE with entry event; 11 -> EN2; 01 -> stay; 10 -> IDLE (abort).
REQ-021 EX1/EX2/EX3 SHALL mirror EN1/EN2/EN3 with a and b swapped, completing with an exit event.
REQ-022 Lane enter_ev/exit_ev SHALL be registered: high for exactly one cycle, the cycle after the edge that sampled the completing 00.
REQ-023 On each edge, occupancy_next = occupancy + popcount(enter_ev) - popcount(exit_ev), computed signed with CNT_W+4 bits.
REQ-024 If the sum exceeds CAPACITY, occupancy SHALL become CAPACITY and ovf SHALL set.
REQ-025 If the sum is below 0, occupancy SHALL become 0 and unf SHALL set.
REQ-026 Occupancy therefore reflects a completed pass 2 cycles after the completing 00 is applied.
REQ-027 Simultaneous events on multiple lanes SHALL all be counted in the same update; entry and exit in the same cycle net out.
REQ-028 full and empty SHALL be combinational decodes of registered occupancy.
REQ-029 clr_err SHALL clear ovf and unf on the next edge; a clamp in that same cycle SHALL win (flag stays set).
REQ-030 Lanes SHALL NOT interact; a lane mid-sequence is unaffected by other lanes or by full.

Reset
REQ-031 reset SHALL force all lanes to IDLE, enter_ev=exit_ev=0, occupancy=0, ovf=unf=0; hence empty=1, full=0.
REQ-032 Reset asserted mid-sequence SHALL discard the partial pass; no event SHALL be emitted after deassertion without a fresh sequence from IDLE.
REQ-033 reset SHALL take priority over clr_err and all events.

Structure
REQ-034 Package parking_pkg SHALL hold the lane state enum (3-bit encoding) and the lane event type.
REQ-035 Sub-module parking_lane_fsm SHALL implement one lane (REQ-016..022), instantiated N_LANES times via generate.
REQ-036 The top SHALL hold the popcount/adder, clamp and sticky flags only.

Verification
REQ-037 Lane0 ab: 00,10,11,01,00 one cycle each -> enter_ev[0] one cycle; occupancy 0->1 two cycles after final 00.
REQ-038 Lane0 ab: 00,01,11,10,00 with occupancy=1 -> exit_ev[0]; occupancy 1->0, empty=1, unf=0.
REQ-039 Lane0 ab: 10,11,10,00 (back-out) -> no event; occupancy unchanged.
REQ-040 CAPACITY=3, N_LANES=2, occupancy=2, both lanes complete entry same cycle -> occupancy=3, full=1, ovf=1; then clr_err -> ovf=0.
REQ-041 occupancy=0, exit on lane1 -> occupancy stays 0, unf=1; reset asserted mid-entry on lane0 (state EN2) -> after release, ab=01,00 yields no event.
REQ-042 Lane0 entry and lane1 exit completing same cycle at occupancy=5 -> both pulses seen, occupancy stays 5.
